// File: rtl/piso_shift_pkg.sv
// piso_shift_pkg
// Shared declarations for the parallel-in / serial-out transmit sequencer.
//   state_t     : controller states (idle, shifting a word, forced gap)
//   idx_width() : width of the bit index counter for a given word length
//   gap_width() : width of the gap counter for a given gap length
package piso_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Never narrower than one bit so a 2-bit word still gets a real counter.
    function automatic int idx_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    // Holds values 0..gap-1; at least one bit even when no gap is configured.
    function automatic int gap_width(input int gap);
        return (gap > 1) ? $clog2(gap) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_datapath.sv
// piso_shift_datapath
// The shift register behind the serial transmitter.
//   clk, rst  : clock, synchronous active-high reset (clears the register)
//   load      : capture din into the register
//   shift     : move the register one place toward the output end, zero fill
//   hold      : freeze the register regardless of load/shift
//   din       : parallel word
//   sout      : bit currently at the output end (bit 0, or bit WIDTH-1 when
//               MSB_FIRST is set)
//   contents  : full register contents
module piso_shift_datapath #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             hold,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic [WIDTH-1:0] contents
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (!hold) begin
            if (load) begin
                shreg <= din;
            end else if (shift) begin
                // Zero fill means the register is empty once a whole word has
                // gone out, so sout reads 0 while the controller is idle.
                if (MSB_FIRST != 0) begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end else begin
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                end
            end
        end
    end

    assign sout     = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign contents = shreg;

endmodule

// File: rtl/piso_shift_ctrl.sv
// piso_shift_ctrl
// Transmit sequencer: accepts a parallel word over valid/ready, shifts it out
// one bit per clock with first/last markers, optionally forcing idle gap
// cycles between words. The consumer can stall everything with hold.
//
// Handshake: a word is taken on a rising edge where din_valid && din_ready.
// din_ready is the only combinational output; it is low during reset and
// hold. The producer keeps din stable until the word is taken.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   din         : parallel word (WIDTH bits)
//   din_valid   : producer has a word on din
//   din_ready   : a word can be accepted this cycle
//   hold        : consumer stall, freezes the whole sequence
//   dout        : serial data bit
//   dout_valid  : dout carries a real bit
//   dout_first  : dout is the first bit of a word
//   dout_last   : dout is the last bit of a word
//   busy        : a word is in flight (shifting or in the gap)
//   bit_idx     : position of the dout bit within the word, 0 = first sent
//   state_dbg   : current controller state (state_t encoding)
//   shreg_dbg   : current shift register contents
//
// Parameters: WIDTH 2..32, GAP 0..15, MSB_FIRST 0/1.
module piso_shift_ctrl
    import piso_shift_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int GAP       = 0,
    parameter int MSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     hold,
    output logic                     dout,
    output logic                     dout_valid,
    output logic                     dout_first,
    output logic                     dout_last,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic [1:0]               state_dbg,
    output logic [WIDTH-1:0]         shreg_dbg
);

    localparam int IW = idx_width(WIDTH);
    localparam int GW = gap_width(GAP);

    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_nxt;
    logic [GW-1:0]   gap_cnt;
    logic [GW-1:0]   gap_nxt;
    logic            load;
    logic            shift;
    logic            accept;
    logic            at_last;

    logic            nxt_valid;
    logic            nxt_first;
    logic            nxt_last;
    logic            nxt_busy;

    assign at_last = (state == ST_SHIFT) && (idx_q == LAST_IDX);

    // A new word can follow the last bit directly only when no gap is wanted.
    assign din_ready = !rst && !hold &&
                       ((state == ST_IDLE) || (at_last && (GAP == 0)));
    assign accept    = din_valid && din_ready;

    // ------------------------------------------------------------------
    // State register (with bit and gap counters)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx_q   <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            idx_q   <= idx_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        gap_nxt   = gap_cnt;
        load      = 1'b0;
        shift     = 1'b0;

        if (!hold) begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_nxt = ST_SHIFT;
                        idx_nxt   = '0;
                        load      = 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (idx_q == LAST_IDX) begin
                        idx_nxt = '0;
                        if (accept) begin
                            load = 1'b1;
                        end else if (GAP > 0) begin
                            // Final shift empties the register.
                            shift     = 1'b1;
                            state_nxt = ST_GAP;
                            gap_nxt   = GAP_LOAD;
                        end else begin
                            shift     = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        shift   = 1'b1;
                        idx_nxt = idx_q + 1'b1;
                    end
                end

                ST_GAP: begin
                    // Leave as the counter reaches zero: the following IDLE
                    // cycle (where din_ready rises) is the last idle slot, so
                    // the serial stream sees GAP empty cycles for GAP >= 2.
                    if (gap_cnt <= GW'(1)) begin
                        state_nxt = ST_IDLE;
                        gap_nxt   = '0;
                    end else begin
                        gap_nxt = gap_cnt - 1'b1;
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                    gap_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: flag values for the coming cycle, registered below.
    // Under hold the next state equals the current one, so the flags keep
    // their values without extra gating.
    // ------------------------------------------------------------------
    always_comb begin
        nxt_valid = (state_nxt == ST_SHIFT);
        nxt_first = (state_nxt == ST_SHIFT) && (idx_nxt == '0);
        nxt_last  = (state_nxt == ST_SHIFT) && (idx_nxt == LAST_IDX);
        nxt_busy  = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dout_valid <= nxt_valid;
            dout_first <= nxt_first;
            dout_last  <= nxt_last;
            busy       <= nxt_busy;
        end
    end

    // ------------------------------------------------------------------
    // Shift register
    // ------------------------------------------------------------------
    piso_shift_datapath #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .hold     (hold),
        .din      (din),
        .sout     (dout),
        .contents (shreg_dbg)
    );

    // The counter is cleared whenever a word finishes, so it already reads 0
    // in IDLE and GAP.
    assign bit_idx   = idx_q;
    assign state_dbg = state;

endmodule
